// File: rtl/event_counter_pkg.sv
// Shared constants for the chained event counter: word slice width and default counter width.
package event_counter_pkg;
  localparam int WORD_W       = 32;
  localparam int XLEN_DEFAULT = 64;
endpackage

// File: rtl/counter_word.sv
// One 32-bit slice of the event counter: parallel load, or increment when the carry-in is high.
module counter_word
  import event_counter_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_cin,
  output logic [WORD_W-1:0] o_word,
  output logic              o_cout
);
  logic [WORD_W-1:0] r_word;

  // Slice register: load has priority, otherwise add the incoming carry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_word <= {WORD_W{1'b0}};
    end else if (i_load) begin
      r_word <= i_wdata;
    end else if (i_cin) begin
      r_word <= r_word + {{(WORD_W-1){1'b0}}, 1'b1};
    end else begin
      r_word <= r_word;
    end
  end

  // Ripple the carry combinationally so a full-width increment settles in one cycle.
  assign o_cout = i_cin & (&r_word);
  assign o_word = r_word;
endmodule

// File: rtl/event_counter.sv
// XLEN-bit event counter built from chained 32-bit slices, with word loads and a sticky overflow flag.
module event_counter
  import event_counter_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              wr_lo,
  input  logic              wr_hi,
  input  logic [WORD_W-1:0] wdata,
  input  logic              ovf_clr,
  output logic [XLEN-1:0]   out,
  output logic              overflow
);
  localparam int NWORDS = XLEN / WORD_W;

  logic [NWORDS:0]   w_carry;
  logic [XLEN-1:0]   w_count;
  logic              w_hi_eff;
  logic              w_load_any;
  logic              r_overflow;

  generate
    if (NWORDS > 1) begin : g_has_hi
      assign w_hi_eff = wr_hi;
    end else begin : g_no_hi
      assign w_hi_eff = 1'b0;
    end
  endgenerate

  // Any load freezes the whole counter for that edge, so no carry enters the chain.
  assign w_load_any = wr_lo | w_hi_eff;
  assign w_carry[0] = enable & ~w_load_any;

  genvar g;
  generate
    for (g = 0; g < NWORDS; g++) begin : g_word
      logic w_load;
      if (g == 0) begin : g_lo
        assign w_load = wr_lo;
      end else if (g == 1) begin : g_hi
        assign w_load = w_hi_eff;
      end else begin : g_upper
        assign w_load = 1'b0;
      end

      counter_word u_word (
        .clk     (clk),
        .resetn  (resetn),
        .i_load  (w_load),
        .i_wdata (wdata),
        .i_cin   (w_carry[g]),
        .o_word  (w_count[g*WORD_W +: WORD_W]),
        .o_cout  (w_carry[g+1])
      );
    end
  endgenerate

  // Sticky overflow: a wrap sets it and beats a simultaneous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
    end else if (w_carry[NWORDS]) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign out      = w_count;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_event_counter.sv
// Self-checking bench for event_counter (XLEN=64): directed scenarios plus randomized traffic vs a reference model.
module tb_event_counter;
  logic        clk;
  logic        resetn;
  logic        enable;
  logic        wr_lo;
  logic        wr_hi;
  logic [31:0] wdata;
  logic        ovf_clr;
  logic [63:0] out;
  logic        overflow;

  int n_pass;
  int n_total;

  logic [63:0] m_cnt;
  logic        m_ovf;

  event_counter #(.XLEN(64)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (enable),
    .wr_lo    (wr_lo),
    .wr_hi    (wr_hi),
    .wdata    (wdata),
    .ovf_clr  (ovf_clr),
    .out      (out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance past the edge and update the reference model.
  task automatic tick(input logic en, input logic lo, input logic hi,
                      input logic [31:0] wd, input logic clr);
    logic wrap;
    enable  = en;
    wr_lo   = lo;
    wr_hi   = hi;
    wdata   = wd;
    ovf_clr = clr;
    @(posedge clk);
    #1;
    wrap = 1'b0;
    if (lo || hi) begin
      if (lo) m_cnt[31:0]  = wd;
      if (hi) m_cnt[63:32] = wd;
    end else if (en) begin
      wrap  = (m_cnt == 64'hFFFF_FFFF_FFFF_FFFF);
      m_cnt = m_cnt + 64'd1;
    end
    if (wrap) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    enable  = 1'b0;
    wr_lo   = 1'b0;
    wr_hi   = 1'b0;
    wdata   = 32'd0;
    ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_total++;
      if (out !== 64'd0 || overflow !== 1'b0)
        $display("FAIL reset_hold cyc=%0d out=%h ovf=%b expected out=0 ovf=0", i, out, overflow);
      else n_pass++;
    end
    resetn = 1'b1;
    m_cnt  = 64'd0;
    m_ovf  = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      n_total++;
      if (out !== 64'(i) || overflow !== 1'b0)
        $display("FAIL reset_release_count got out=%h ovf=%b expected out=%h ovf=0", out, overflow, 64'(i));
      else n_pass++;
    end
  endtask

  task automatic test_full_wrap();
    tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    n_total++;
    if (out !== 64'hFFFF_FFFF_FFFF_FFFF || overflow !== 1'b0)
      $display("FAIL wrap_load got out=%h ovf=%b expected out=ffffffffffffffff ovf=0", out, overflow);
    else n_pass++;
    tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    n_total++;
    if (out !== 64'd0 || overflow !== 1'b1)
      $display("FAIL wrap_incr got out=%h ovf=%b expected out=0 ovf=1", out, overflow);
    else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    n_total++;
    if (overflow !== 1'b0)
      $display("FAIL wrap_clear got ovf=%b expected 0", overflow);
    else n_pass++;
  endtask

  task automatic test_carry();
    tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0);
    n_total++;
    if (out !== 64'h0000_0000_FFFF_FFFF)
      $display("FAIL carry_hi_only_load got out=%h expected 00000000ffffffff", out);
    else n_pass++;
    tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    n_total++;
    if (out !== 64'h0000_0001_0000_0000 || overflow !== 1'b0)
      $display("FAIL carry_propagate got out=%h ovf=%b expected 0000000100000000 ovf=0", out, overflow);
    else n_pass++;
  endtask

  task automatic test_load_priority();
    tick(1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b0);
    n_total++;
    if (out !== 64'h0000_0001_0000_0010)
      $display("FAIL load_beats_incr got out=%h expected 0000000100000010", out);
    else n_pass++;
    tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    n_total++;
    if (out !== 64'h0000_0001_0000_0011)
      $display("FAIL incr_after_load got out=%h expected 0000000100000011", out);
    else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    n_total++;
    if (out !== 64'h0000_0001_0000_0011)
      $display("FAIL hold_no_enable got out=%h expected 0000000100000011", out);
    else n_pass++;
  endtask

  task automatic test_ovf_clr();
    tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    n_total++;
    if (overflow !== 1'b1)
      $display("FAIL load_keeps_ovf got ovf=%b expected 1", overflow);
    else n_pass++;
    tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    n_total++;
    if (out !== 64'd0 || overflow !== 1'b1)
      $display("FAIL wrap_beats_clr got out=%h ovf=%b expected out=0 ovf=1", out, overflow);
    else n_pass++;
    tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    n_total++;
    if (overflow !== 1'b1)
      $display("FAIL ovf_sticky got ovf=%b expected 1", overflow);
    else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    n_total++;
    if (overflow !== 1'b0 || out !== 64'd1)
      $display("FAIL clr_alone got out=%h ovf=%b expected out=1 ovf=0", out, overflow);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    #1;
    resetn = 1'b0;
    #1;
    n_total++;
    if (out !== 64'd0 || overflow !== 1'b0)
      $display("FAIL async_reset got out=%h ovf=%b expected out=0 ovf=0", out, overflow);
    else n_pass++;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    m_cnt  = 64'd0;
    m_ovf  = 1'b0;
  endtask

  task automatic test_random();
    logic        en, lo, hi, clr;
    logic [31:0] wd;
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      lo  = ($urandom_range(0, 9) == 0);
      hi  = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       wd = 32'hFFFF_FFFF;
        1:       wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: wd = $urandom;
      endcase
      tick(en, lo, hi, wd, clr);
      n_total++;
      if (out !== m_cnt || overflow !== m_ovf)
        $display("FAIL random cyc=%0d got out=%h ovf=%b expected out=%h ovf=%b",
                 i, out, overflow, m_cnt, m_ovf);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    resetn  = 1'b0;
    enable  = 1'b0;
    wr_lo   = 1'b0;
    wr_hi   = 1'b0;
    wdata   = 32'd0;
    ovf_clr = 1'b0;
    m_cnt   = 64'd0;
    m_ovf   = 1'b0;
    #1;
    n_total++;
    if (out !== 64'd0 || overflow !== 1'b0)
      $display("FAIL initial_reset got out=%h ovf=%b expected out=0 ovf=0", out, overflow);
    else n_pass++;
    test_reset();
    test_full_wrap();
    test_carry();
    test_load_priority();
    test_ovf_clr();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
